// File: rtl/trace_pkg.sv
// Shared states, format codes, character constants and error bits
// for the streaming trace line parser.
package trace_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_TIME,
    S_PC,
    S_COLON,
    S_SP1,
    S_REG,
    S_ADDR,
    S_SP2,
    S_EQ,
    S_SP3,
    S_DATA,
    S_HASH
  } state_t;

  localparam logic [1:0] FMT_NONE = 2'b00;
  localparam logic [1:0] FMT_REG  = 2'b01;
  localparam logic [1:0] FMT_MEM  = 2'b10;

  localparam logic [7:0] C_CARET  = 8'h5e;
  localparam logic [7:0] C_AT     = 8'h40;
  localparam logic [7:0] C_COLON  = 8'h3a;
  localparam logic [7:0] C_DOLLAR = 8'h24;
  localparam logic [7:0] C_STAR   = 8'h2a;
  localparam logic [7:0] C_LT     = 8'h3c;
  localparam logic [7:0] C_EQ     = 8'h3d;
  localparam logic [7:0] C_HASH   = 8'h23;
  localparam logic [7:0] C_SPACE  = 8'h20;
  localparam logic [7:0] C_0      = 8'h30;
  localparam logic [7:0] C_9      = 8'h39;
  localparam logic [7:0] C_A      = 8'h61;
  localparam logic [7:0] C_F      = 8'h66;

  localparam int ERR_PC   = 0;
  localparam int ERR_ADDR = 1;
  localparam int ERR_REG  = 2;
  localparam int ERR_R0   = 3;

endpackage

// File: rtl/trace_char_class.sv
// Character classifier: decimal / lowercase hex detection and the
// nibble value of a hex digit.
module trace_char_class
  import trace_pkg::*;
(
  input  logic [7:0] char,
  output logic       is_dec,
  output logic       is_hex,
  output logic [3:0] nibble
);

  logic is_af;

  assign is_dec = (char >= C_0) && (char <= C_9);
  assign is_af  = (char >= C_A) && (char <= C_F);
  assign is_hex = is_dec | is_af;
  // 'a'..'f' have low nibbles 1..6
  assign nibble = is_af ? (char[3:0] + 4'd9) : char[3:0];

endmodule

// File: rtl/trace_line_parser.sv
// Streaming trace line checker; semantic error flags are built only
// when TRACE_SEMANTIC_CHECK_EN is defined.
module trace_line_parser
  import trace_pkg::*;
#(
  parameter int          TIME_DIGITS_MAX = 4,
  parameter int          REG_DIGITS_MAX  = 4,
  parameter int          HEX_DIGITS      = 8,
  parameter logic [31:0] PC_LO           = 32'h0000_3000,
  parameter logic [31:0] PC_HI           = 32'h0000_6ffc,
  parameter logic [31:0] ADDR_HI         = 32'h0000_2ffc
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   char,
  input  logic                         char_valid,
  output logic [1:0]                   format_type,
  output logic                         line_done,
  output logic [4*TIME_DIGITS_MAX-1:0] time_val,
  output logic [31:0]                  pc_val,
  output logic [31:0]                  dest_val,
  output logic [31:0]                  data_val,
  output logic [3:0]                   error_code
);

  localparam int TW = 4 * TIME_DIGITS_MAX;
  localparam int RW = 4 * REG_DIGITS_MAX;
  localparam int HW = 4 * HEX_DIGITS;
  localparam logic [7:0] TMAX = 8'(TIME_DIGITS_MAX);
  localparam logic [7:0] RMAX = 8'(REG_DIGITS_MAX);
  localparam logic [7:0] HMAX = 8'(HEX_DIGITS);

  state_t        state;
  logic [7:0]    cnt;
  logic [TW-1:0] t_acc;
  logic [RW-1:0] r_acc;
  logic [HW-1:0] p_acc;
  logic [HW-1:0] a_acc;
  logic [HW-1:0] d_acc;
  logic          mem;
  logic          is_dec;
  logic          is_hex;
  logic [3:0]    nib;
  logic          done;
  logic [3:0]    err;
  logic [31:0]   pc32;
  logic [31:0]   dst32;
  logic [31:0]   dat32;

  trace_char_class u_cls (
    .char   (char),
    .is_dec (is_dec),
    .is_hex (is_hex),
    .nibble (nib)
  );

  assign done  = char_valid && (state == S_HASH)
              && (char == C_HASH);
  assign pc32  = 32'(p_acc);
  assign dst32 = mem ? 32'(a_acc) : 32'(r_acc);
  assign dat32 = 32'(d_acc);

`ifdef TRACE_SEMANTIC_CHECK_EN
  always_comb begin
    err = 4'b0000;
    err[ERR_PC] = (pc32 < PC_LO) || (pc32 > PC_HI)
               || (pc32[1:0] != 2'b00);
    if (mem) begin
      err[ERR_ADDR] = (dst32 > ADDR_HI)
                   || (dst32[1:0] != 2'b00);
    end else begin
      err[ERR_REG] = dst32 > 32'd31;
      err[ERR_R0]  = (dst32 == 32'd0) && (dat32 != 32'd0);
    end
  end
`else
  assign err = 4'b0000;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      t_acc       <= '0;
      r_acc       <= '0;
      p_acc       <= '0;
      a_acc       <= '0;
      d_acc       <= '0;
      mem         <= 1'b0;
      format_type <= FMT_NONE;
      line_done   <= 1'b0;
      time_val    <= '0;
      pc_val      <= '0;
      dest_val    <= '0;
      data_val    <= '0;
      error_code  <= '0;
    end else begin
      format_type <= FMT_NONE;
      line_done   <= 1'b0;
      if (done) begin
        format_type <= mem ? FMT_MEM : FMT_REG;
        line_done   <= 1'b1;
        time_val    <= t_acc;
        pc_val      <= pc32;
        dest_val    <= dst32;
        data_val    <= dat32;
        error_code  <= err;
      end
      if (char_valid && char == C_CARET) begin
        state <= S_TIME;
        cnt   <= '0;
        t_acc <= '0;
        r_acc <= '0;
        p_acc <= '0;
        a_acc <= '0;
        d_acc <= '0;
        mem   <= 1'b0;
      end else if (char_valid) begin
        // anything not matched below drops back to idle
        state <= S_IDLE;
        unique case (state)
          S_TIME: begin
            if (is_dec && cnt < TMAX) begin
              state <= S_TIME;
              t_acc <= t_acc * TW'(10) + TW'(nib);
              cnt   <= cnt + 8'd1;
            end else if (char == C_AT && cnt != 8'd0) begin
              state <= S_PC;
              cnt   <= '0;
            end
          end
          S_PC: begin
            if (is_hex && cnt < HMAX) begin
              state <= S_PC;
              p_acc <= (p_acc << 4) | HW'(nib);
              cnt   <= cnt + 8'd1;
            end else if (char == C_COLON && cnt == HMAX) begin
              state <= S_COLON;
            end
          end
          S_COLON, S_SP1: begin
            if (char == C_SPACE) begin
              state <= S_SP1;
            end else if (char == C_DOLLAR) begin
              state <= S_REG;
              cnt   <= '0;
              mem   <= 1'b0;
            end else if (char == C_STAR) begin
              state <= S_ADDR;
              cnt   <= '0;
              mem   <= 1'b1;
            end
          end
          S_REG: begin
            if (is_dec && cnt < RMAX) begin
              state <= S_REG;
              r_acc <= r_acc * RW'(10) + RW'(nib);
              cnt   <= cnt + 8'd1;
            end else if (char == C_SPACE && cnt != 8'd0) begin
              state <= S_SP2;
            end else if (char == C_LT && cnt != 8'd0) begin
              state <= S_EQ;
            end
          end
          S_ADDR: begin
            if (is_hex && cnt < HMAX) begin
              state <= S_ADDR;
              a_acc <= (a_acc << 4) | HW'(nib);
              cnt   <= cnt + 8'd1;
            end else if (char == C_SPACE && cnt == HMAX) begin
              state <= S_SP2;
            end else if (char == C_LT && cnt == HMAX) begin
              state <= S_EQ;
            end
          end
          S_SP2: begin
            if (char == C_SPACE) state <= S_SP2;
            else if (char == C_LT) state <= S_EQ;
          end
          S_EQ: begin
            if (char == C_EQ) state <= S_SP3;
          end
          S_SP3: begin
            if (char == C_SPACE) begin
              state <= S_SP3;
            end else if (is_hex) begin
              d_acc <= HW'(nib);
              cnt   <= 8'd1;
              state <= (HMAX == 8'd1) ? S_HASH : S_DATA;
            end
          end
          S_DATA: begin
            if (is_hex) begin
              d_acc <= (d_acc << 4) | HW'(nib);
              cnt   <= cnt + 8'd1;
              state <= (cnt + 8'd1 == HMAX) ? S_HASH : S_DATA;
            end
          end
          S_HASH, S_IDLE: ;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/trace_line_parser.md
# trace_line_parser

Parametrised streaming checker for CPU trace lines, one ASCII character per accepted cycle. It recognises register-write lines (`^<time>@<pc>: $<reg> <= <data>#`) and memory-write lines (`^<time>@<pc>: *<addr> <= <data>#`). On each complete line it reports the format and the captured fields, and, when compiled in, semantic error flags. It sits behind the UART/char source in the pre-lab checker harness and replaces the fixed-width checker of the previous generation.

## Interface
- TIME_DIGITS_MAX, 4: maximum decimal digits in the time field (minimum 1).
- REG_DIGITS_MAX, 4: maximum decimal digits in the register number (minimum 1).
- HEX_DIGITS, 8: exact count of lowercase hex digits in the pc, addr and data fields (1..8).
- PC_LO, 32'h0000_3000: lowest legal pc.
- PC_HI, 32'h0000_6ffc: highest legal pc.
- ADDR_HI, 32'h0000_2ffc: highest legal memory address.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- char  in  8  ASCII character.
- char_valid  in  1  char is consumed on this edge. When low, the FSM, counters and accumulators hold.
- format_type  out  2  00 none, 01 register line, 10 memory line. One-cycle pulse.
- line_done  out  1  high exactly when format_type != 00.
- time_val  out  4*TIME_DIGITS_MAX  binary value of the time field.
- pc_val  out  32  pc, zero-extended from 4*HEX_DIGITS bits.
- dest_val  out  32  register number (zero-extended) or memory address.
- data_val  out  32  data field, zero-extended.
- error_code  out  4  semantic flags, valid while line_done is high.

## Operation
- Grammar, in order:
  - `^`
  - 1..TIME_DIGITS_MAX decimal digits
  - `@`
  - exactly HEX_DIGITS hex digits
  - `:`
  - zero or more spaces
  - either `$` followed by 1..REG_DIGITS_MAX decimal digits, or `*` followed by exactly HEX_DIGITS hex digits
  - zero or more spaces
  - `<=`
  - zero or more spaces
  - exactly HEX_DIGITS hex digits
  - `#`
- Hex digits are `0`-`9` and `a`-`f` only. Uppercase is illegal.
- States: IDLE, TIME, PC, COLON, SP1, REG, ADDR, SP2, EQ, SP3, DATA, HASH. A digit counter tracks field length inside TIME, PC, REG, ADDR and DATA.
- Restart rule: `^` accepted in any state (including IDLE) moves to TIME with the counter, accumulators and branch flag cleared.
- Any other character not allowed by the grammar moves to IDLE. No state may retain on an illegal character.
- Too many digits, or `@`/space/`<` seen with zero digits, is illegal and moves to IDLE.
- Accumulators:
  - Decimal fields: acc = acc*10 + d, sized 4*DIGITS_MAX bits. No overflow is possible.
  - Hex fields: acc = {acc, nibble}.
- On an accepted `#` in HASH:
  - Next edge: format_type = 01 or 10 according to the branch, line_done = 1.
  - All *_val outputs and error_code load from the accumulators.
  - FSM returns to IDLE.
- The following edge clears format_type and line_done regardless of char_valid. *_val outputs hold until the next completed line.
- error_code (with the feature compiled in):
  - bit0: pc < PC_LO, or pc > PC_HI, or pc[1:0] != 0.
  - bit1: memory line only. addr > ADDR_HI or addr[1:0] != 0.
  - bit2: register line only. reg > 31.
  - bit3: register line with reg == 0 and data != 0.
  - Bits that do not apply to the branch are 0.
- Reset values: FSM IDLE; format_type 00; line_done 0; all *_val 0; error_code 0.

## Timing
- Latency: format_type rises on the edge that samples the `#` (visible in the following cycle). Width is exactly one cycle.
- Back-to-back lines: a `^` accepted on the same edge that format_type is cleared starts the next line normally.
- char_valid low during the pulse cycle does not extend the pulse.
- Reset asserted mid-line discards the partial line. No pulse follows.
- Reset asserted on the `#` edge wins: format_type stays 00.

## Configuration
- TRACE_SEMANTIC_CHECK_EN defined: error_code computed as above. The range comparators are instantiated.
- TRACE_SEMANTIC_CHECK_EN undefined: error_code is tied to 4'b0000. The comparators are removed. Format acceptance and field capture are unchanged.

## Structure
- Package trace_pkg holds:
  - the state enum
  - the format codes FMT_NONE / FMT_REG / FMT_MEM
  - character constants (`^`, `@`, `:`, `$`, `*`, `<`, `=`, `#`, space)
  - error-bit index constants
- Sub-module trace_char_class (combinational): char -> is_dec, is_hex, nibble[3:0].

## Test plan
- `^12@00003000: $5 <= 0000abcd#` -> one-cycle format_type 01; time_val 12; pc_val 0x3000; dest_val 5; data_val 0xabcd; error_code 0.
- `^7@00003004:*00000010<=deadbeef#` -> format_type 10; dest_val 0x10; data_val 0xdeadbeef; error_code 0.
- `^1@0000^2@00003000: $1 <=00000001#` -> exactly one pulse, with time_val 2.
- Illegal lines produce no pulse and leave the *_val outputs unchanged:
  - `^12345@...` with TIME_DIGITS_MAX=4
  - uppercase `A` in pc
  - `<` not followed by `=`
- `^3@00003002: $40 <= 00000000#` with the macro defined -> format_type 01, error_code 4'b0101. Without the macro -> error_code 0.
- Reset asserted after `^9@0000300` then a full valid line -> only the second line pulses. char_valid toggled low every other cycle across a valid line -> the same result as continuous input.
